// File: rtl/data_sram_axi_bridge_if.sv
// rtl/data_sram_axi_bridge_if.sv - signal bundle between the core data port, the bridge and the AXI4-Lite fabric
// Purpose: groups the core's SRAM-like data port and the AXI4-Lite channels into one bundle.
// Modports:
//   master  bridge view: serves the SRAM-like port, drives the AXI4-Lite master channels
//   slave   environment view: the core issues SRAM-like requests, the fabric answers AXI
// Signals:
//   data_sram_req/wr/wstrb/addr/wdata            core request
//   data_sram_addr_ok/data_ok/rdata              bridge response to the core
//   araddr/arvalid/arready, rdata/rresp/rvalid/rready              AXI read channels
//   awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI write channels
interface data_sram_axi_bridge_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// rtl/data_sram_axi_bridge.sv - CPU data-side SRAM-like port to single-beat AXI4-Lite master bridge
// Purpose: turns one load/store request from the pipeline's data port into one AXI4-Lite
//   read (AR then R) or write (AW and W, then B), with a single transaction in flight.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     data_sram_axi_bridge_if.master - SRAM-like request/response plus AXI4-Lite channels
// Build option: BRIDGE_POSTED_WR_EN - when defined, a store reports data_ok as soon as
//   AW and W have both handshaken; the bridge still waits for B before accepting again.
module data_sram_axi_bridge (
  input  logic                   clk,
  input  logic                   resetn,
  data_sram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_AR    = 3'd1,
    RD_R     = 3'd2,
    WR_AW_W  = 3'd3,
    WR_B     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_aw_done;
  logic        r_w_done;
  logic        r_data_ok;
  logic [31:0] r_rdata;
  logic [31:0] r_araddr;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        w_addr_ok;
  logic        w_arvalid;
  logic        w_rready;
  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_bready;

  logic        w_accept;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_aw_w_done;
  logic        w_wr_complete;

  // Response codes are not reported back to the core.
  logic        w_unused_resp;
  assign w_unused_resp = ^{bus.rresp, bus.bresp};

  assign w_accept = w_addr_ok;
  assign w_ar_hs  = w_arvalid && bus.arready;
  assign w_r_hs   = w_rready  && bus.rvalid;
  assign w_aw_hs  = w_awvalid && bus.awready;
  assign w_w_hs   = w_wvalid  && bus.wready;
  assign w_b_hs   = w_bready  && bus.bvalid;

  // Both write address and data have handshaken, either earlier (sticky flag) or now.
  assign w_aw_w_done = (r_state == WR_AW_W) &&
                       (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

`ifdef BRIDGE_POSTED_WR_EN
  assign w_wr_complete = w_aw_w_done;
`else
  assign w_wr_complete = w_b_hs;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = bus.data_sram_wr ? WR_AW_W : RD_AR;
      RD_AR:   if (w_ar_hs) w_next_state = RD_R;
      RD_R:    if (w_r_hs) w_next_state = IDLE;
      WR_AW_W: if (w_aw_w_done) w_next_state = WR_B;
      WR_B:    if (w_b_hs) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic; addr_ok is gated by resetn so it stays low while reset is held.
  always_comb begin
    w_addr_ok = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    case (r_state)
      IDLE:    w_addr_ok = bus.data_sram_req && resetn;
      RD_AR:   w_arvalid = 1'b1;
      RD_R:    w_rready  = 1'b1;
      WR_AW_W: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      WR_B:    w_bready  = 1'b1;
      default: ;
    endcase
  end

  // Request payload, sticky handshake flags and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      // Payload registers only load on accept, so they hold between transactions.
      if (w_accept) begin
        if (bus.data_sram_wr) begin
          r_awaddr <= bus.data_sram_addr;
          r_wdata  <= bus.data_sram_wdata;
          r_wstrb  <= bus.data_sram_wstrb;
        end else begin
          r_araddr <= bus.data_sram_addr;
        end
      end
      if (w_aw_w_done) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if (w_r_hs) r_rdata <= bus.rdata;
      r_data_ok <= w_r_hs || w_wr_complete;
    end
  end

  assign bus.data_sram_addr_ok = w_addr_ok;
  assign bus.data_sram_data_ok = r_data_ok;
  assign bus.data_sram_rdata   = r_rdata;
  assign bus.araddr            = r_araddr;
  assign bus.arvalid           = w_arvalid;
  assign bus.rready            = w_rready;
  assign bus.awaddr            = r_awaddr;
  assign bus.awvalid           = w_awvalid;
  assign bus.wdata             = r_wdata;
  assign bus.wstrb             = r_wstrb;
  assign bus.wvalid            = w_wvalid;
  assign bus.bready            = w_bready;

endmodule
